// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, write strobes and the alu function select.
module mc_control_unit #(
    parameter int         STATE_W  = 4,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pcen,
    output logic [1:0]         pcsrc,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         alucontrol,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXECUTE = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_ADDIEX  = STATE_W'(9),
        S_ADDIWB  = STATE_W'(10),
        S_JUMP    = STATE_W'(11)
    } state_t;

    state_t     state_r;
    state_t     state_nxt;
    state_t     dec_st;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    function automatic logic [2:0] alu_dec(input logic [1:0] aop, input logic [5:0] f);
        logic [2:0] r;
        case (aop)
            2'b00:   r = 3'b010;
            2'b01:   r = 3'b110;
            default: begin
                case (f)
                    6'b100000: r = 3'b010;
                    6'b100010: r = 3'b110;
                    6'b100100: r = 3'b000;
                    6'b100101: r = 3'b001;
                    6'b101010: r = 3'b111;
                    default:   r = 3'b010;
                endcase
            end
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state_r <= S_FETCH;
        else        state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state_r)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_nxt = S_MEMADR;
                else if (op == OP_RTYPE)        state_nxt = S_EXECUTE;
                else if (op == OP_BEQ)          state_nxt = S_BRANCH;
                else if (op == OP_ADDI)         state_nxt = S_ADDIEX;
                else if (op == OP_J)            state_nxt = S_JUMP;
                else                            state_nxt = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_nxt = S_MEMRD;
                else if (op == OP_SW) state_nxt = S_MEMWR;
                else                  state_nxt = S_FETCH;
            end
            S_MEMRD:   state_nxt = S_MEMWB;
            S_EXECUTE: state_nxt = S_ALUWB;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // While reset is held the outputs decode as FETCH, with every write strobe suppressed.
    always_comb begin
        dec_st   = reset ? state_r : S_FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        aluop    = 2'b00;
        pcsrc    = 2'b00;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        case (dec_st)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
        end
        pcen       = pcwrite | (branch & zero);
        alucontrol = alu_dec(aluop, funct);
    end

    assign state = state_r;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a per-instruction state-path model checked
// against the DUT every cycle, plus hand-computed spot checks.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_st   = 0;
    bit exp_valid = 1'b0;

    always #5 clk = ~clk;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .pcsrc(pcsrc), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .state(state)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    // Packed as {pcen,pcsrc,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,alucontrol,state}
    function automatic logic [18:0] model(input int s, input logic rst, input logic [5:0] o,
                                          input logic [5:0] f, input logic z);
        logic pw = 0, br = 0, io = 0, mw = 0, ir = 0, rd = 0, mr = 0, rw = 0, sa = 0;
        logic [1:0] ps = 0, sb = 0;
        logic [2:0] ac = 3'b010;
        logic pe;
        int ds = rst ? s : 0;
        case (ds)
            0:  begin ir = 1; pw = 1; sb = 2'b01; end
            1:  sb = 2'b11;
            2, 9: begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin mr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin
                    sa = 1;
                    if (f == 6'b100010) ac = 3'b110;
                    else if (f == 6'b100100) ac = 3'b000;
                    else if (f == 6'b100101) ac = 3'b001;
                    else if (f == 6'b101010) ac = 3'b111;
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = 3'b110; ps = 2'b01; br = 1; end
            10: rw = 1;
            11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        pe = pw | (br & z);
        if (!rst) begin pe = 0; ir = 0; mw = 0; rw = 0; end
        return {pe, ps, io, mw, ir, rd, mr, rw, sa, sb, ac, 4'(s)};
    endfunction

    always @(negedge clk) begin
        if (exp_valid)
            chk($sformatf("outputs st%0d op%b", exp_st, op),
                {13'd0, pcen, pcsrc, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                 alusrca, alusrcb, alucontrol, state},
                {13'd0, model(exp_st, reset, op, funct, zero)});
    end

    task automatic settle(input int s);
        exp_st = s;
        #2;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        int seq[$];
        op = o; funct = f; zero = z;
        case (o)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000100: seq = '{0, 1, 8};
            6'b000010: seq = '{0, 1, 11};
            default:   seq = '{0, 1};
        endcase
        foreach (seq[i]) begin
            settle(seq[i]);
            adv();
        end
    endtask

    initial begin
        reset = 1'b0; op = 6'b000000; funct = 6'b100010; zero = 1'b0;
        adv();
        exp_valid = 1'b1;
        settle(0);
        chk("reset state", 32'(state), 0);
        chk("reset pcen", 32'(pcen), 0);
        chk("reset irwrite", 32'(irwrite), 0);
        adv();
        settle(0);
        chk("reset2 state", 32'(state), 0);
        adv();
        reset = 1'b1;
        settle(0);
        chk("fetch pcen", 32'(pcen), 1);
        chk("fetch irwrite", 32'(irwrite), 1);
        chk("fetch alucontrol", 32'(alucontrol), 32'b010);
        chk("fetch alusrcb", 32'(alusrcb), 32'b01);
        adv();
        settle(1);
        adv();
        settle(6);
        chk("execute sub alucontrol", 32'(alucontrol), 32'b110);
        chk("execute alusrca", 32'(alusrca), 1);
        adv();
        settle(7);
        chk("aluwb regdst", 32'(regdst), 1);
        chk("aluwb regwrite", 32'(regwrite), 1);
        adv();

        op = 6'b100011;
        settle(0); adv(); settle(1); adv(); settle(2); adv();
        settle(3);
        chk("lw memrd iord", 32'(iord), 1);
        chk("lw memrd regwrite", 32'(regwrite), 0);
        adv();
        settle(4);
        chk("lw memwb regwrite", 32'(regwrite), 1);
        chk("lw memwb memtoreg", 32'(memtoreg), 1);
        adv();

        op = 6'b000100; zero = 1'b1;
        settle(0); adv(); settle(1); adv();
        settle(8);
        chk("beq taken pcen", 32'(pcen), 1);
        chk("beq pcsrc", 32'(pcsrc), 32'b01);
        chk("beq alucontrol", 32'(alucontrol), 32'b110);
        adv();
        zero = 1'b0;
        settle(0); adv(); settle(1); adv();
        settle(8);
        chk("beq not taken pcen", 32'(pcen), 0);
        adv();

        op = 6'b111111;
        settle(0); adv();
        settle(1);
        chk("illegal decode memwrite", 32'(memwrite), 0);
        chk("illegal decode regwrite", 32'(regwrite), 0);
        chk("illegal decode pcen", 32'(pcen), 0);
        adv();

        op = 6'b101011;
        settle(0); adv(); settle(1); adv(); settle(2); adv();
        settle(5);
        chk("sw memwr memwrite", 32'(memwrite), 1);
        reset = 1'b0;
        #1;
        chk("sw reset memwrite", 32'(memwrite), 0);
        chk("sw reset alucontrol", 32'(alucontrol), 32'b010);
        adv();
        settle(0);
        chk("sw reset state", 32'(state), 0);
        adv();
        reset = 1'b1;

        run_instr(6'b001000, 6'b000000, 1'b0);
        run_instr(6'b000010, 6'b000000, 1'b1);
        run_instr(6'b000000, 6'b100000, 1'b0);
        run_instr(6'b000000, 6'b100100, 1'b0);
        run_instr(6'b000000, 6'b100101, 1'b1);
        run_instr(6'b000000, 6'b101010, 1'b0);
        run_instr(6'b000000, 6'b111111, 1'b0);
        run_instr(6'b101011, 6'b000000, 1'b0);
        run_instr(6'b100011, 6'b000000, 1'b1);
        run_instr(6'b000011, 6'b000000, 1'b0);
        run_instr(6'b000100, 6'b000000, 1'b1);

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
